subtractor_serial: RTL and testbench
====================================

Name: subtractor_serial

Overview:
- Bit-serial two's-complement subtractor: computes a_i - b_i one bit per clock, LSB first, using a single full-subtractor cell and a borrow flop.
- Inverse operation of the team's ripple-carry adder; result format mirrors it, a width_p+1 bit result.
- Ready/valid handshake on both sides; used in area-constrained datapaths where width_p-cycle latency is acceptable.

Parameters:
- width_p, 5, operand width in bits; legal range 1 to 64.

Ports:
- clk_i  input  1  clock, rising edge
- reset_i  input  1  asynchronous, active-high reset
- a_i  input  width_p  minuend, unsigned
- b_i  input  width_p  subtrahend, unsigned
- valid_i  input  1  operands valid
- ready_o  output  1  block can accept operands
- diff_o  output  width_p+1  a_i - b_i as a width_p+1 bit two's-complement value; bit width_p = borrow out
- valid_o  output  1  diff_o valid
- ready_i  input  1  consumer accepts diff_o

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state = IDLE, valid_o = 0, diff_o = 0, internal borrow = 0, bit counter = 0.
- ready_o is 0 while reset_i is high.
- States:
  - IDLE: ready_o = 1. On valid_i & ready_o, capture a_i and b_i into shift registers, clear the borrow, clear the counter, and go to BUSY.
  - BUSY: ready_o = 0, valid_o = 0. Each cycle, process bit d = a^b^borrow and borrow_next = (~a&b) | (~(a^b)&borrow). Shift d into the result register MSB-first so the LSB lands at bit 0 after width_p shifts. Increment the counter. After the width_p-th bit, write the final borrow into diff_o[width_p] and go to DONE.
  - DONE: valid_o = 1 and diff_o is held stable. On ready_i, go to IDLE and drop valid_o. ready_o stays 0 in DONE, so there is no same-cycle accept.
- Latency: the accept edge is T, and valid_o is first high after edge T+width_p. Throughput is at most one operation per width_p+2 cycles.
- Handshake rules:
  - valid_i is ignored outside IDLE. Operands presented then are not captured, and the source must hold them until ready_o.
  - Once asserted, valid_o stays high with diff_o constant until ready_i is sampled high.
  - a_i and b_i changes after acceptance have no effect.
- Arithmetic: diff_o equals the signed result of a_i - b_i, in range -(2^width_p - 1) to 2^width_p - 1. diff_o[width_p] = 1 exactly when a_i < b_i.
- Counter width: $clog2(width_p+1).
- width_p = 1: BUSY lasts exactly one cycle.
- Reset mid-operation: reset asserted in BUSY or DONE returns immediately to the reset values. The partial result is discarded and no valid_o is produced.
- Between operations diff_o retains its last value. Only its value while valid_o = 1 is defined for checking.

Optional Feature:
- Macro: SUBTRACTOR_SERIAL_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero_o (1 bit, reset 0).
  - zero_o is registered alongside diff_o. It is 1 when diff_o is all zeros (a_i == b_i) and is valid only while valid_o = 1.
  - Implemented with a sticky OR of produced difference bits; no wide compare.
- Undefined: zero_o port and its logic are absent, and all other behaviour is identical.

Test Plan:
- width_p=5, a=9, b=4, ready_i=1 -> valid_o after 5 cycles in BUSY, diff_o = 6'b000101, returns to IDLE.
- a=4, b=9 -> diff_o = 6'b111011 (-5), diff_o[5] = 1; with the macro defined, zero_o = 0.
- Boundaries: a=31, b=0 -> 6'b011111; a=0, b=31 -> 6'b100001; a=17, b=17 -> 6'b000000, with zero_o = 1 when the macro is defined.
- Backpressure: ready_i held 0 for 3 cycles in DONE -> valid_o and diff_o held stable for 3 cycles, ready_o stays 0; ready_i=1 -> IDLE next cycle.
- valid_i pulsed with a=1, b=2 during BUSY of a=9, b=4 -> ignored; result 5 only, no second valid_o.
- reset_i asserted for 1 cycle at the 3rd BUSY cycle -> valid_o = 0 and diff_o = 0 immediately; ready_o = 1 after release; a new op a=3, b=1 yields 6'b000010.

Source files
------------

// File: rtl/subtractor_serial_if.sv
// Operand/result handshake bundle for subtractor_serial.
// zero_o exists only when SUBTRACTOR_SERIAL_ZERO_FLAG_EN is defined.
interface subtractor_serial_if #(
  parameter int unsigned width_p = 5
);
  logic [width_p-1:0] a_i;
  logic [width_p-1:0] b_i;
  logic               valid_i;
  logic               ready_o;
  logic [width_p:0]   diff_o;
  logic               valid_o;
  logic               ready_i;
`ifdef SUBTRACTOR_SERIAL_ZERO_FLAG_EN
  logic               zero_o;
`endif

  modport slave (
    input  a_i, b_i, valid_i, ready_i,
`ifdef SUBTRACTOR_SERIAL_ZERO_FLAG_EN
    output zero_o,
`endif
    output ready_o, diff_o, valid_o
  );

  modport master (
    output a_i, b_i, valid_i, ready_i,
`ifdef SUBTRACTOR_SERIAL_ZERO_FLAG_EN
    input  zero_o,
`endif
    input  ready_o, diff_o, valid_o
  );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial two's-complement subtractor, LSB first, one full-subtractor cell.
// Optional zero flag enabled by SUBTRACTOR_SERIAL_ZERO_FLAG_EN.
module subtractor_serial #(
  parameter int unsigned width_p = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  subtractor_serial_if.slave   bus
);
  localparam int unsigned cnt_w_lp = $clog2(width_p + 1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q, state_d;
  logic [width_p-1:0]    a_q, b_q;
  logic                  borrow_q;
  logic [cnt_w_lp-1:0]   cnt_q;
  logic [width_p:0]      diff_q;
  logic                  accept, last_bit, d_bit, borrow_next;
  logic                  ready, valid;
  logic [width_p-1:0]    res_shift;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    valid    = 1'b0;
    accept   = 1'b0;
    last_bit = (cnt_q == last_cnt_lp);
    case (state_q)
      IDLE: begin
        ready = ~reset_i;
        if (bus.valid_i && !reset_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: if (last_bit) state_d = DONE;
      DONE: begin
        valid = 1'b1;
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs; result shifts in from the top
  // so the first bit produced ends up at bit 0 after width_p shifts.
  always_comb begin
    d_bit       = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    res_shift   = diff_q[width_p-1:0] >> 1;
    res_shift[width_p-1] = d_bit;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
    end else if (accept) begin
      a_q      <= bus.a_i;
      b_q      <= bus.b_i;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= borrow_next;
      cnt_q    <= cnt_q + cnt_w_lp'(1);
      diff_q[width_p-1:0] <= res_shift;
      if (last_bit) diff_q[width_p] <= borrow_next;
    end
  end

`ifdef SUBTRACTOR_SERIAL_ZERO_FLAG_EN
  logic nz_q, zero_q;

  // Sticky OR of produced bits; with a zero difference the borrow is also 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      nz_q   <= 1'b0;
    end else if (state_q == BUSY) begin
      nz_q <= nz_q | d_bit;
      if (last_bit) zero_q <= ~(nz_q | d_bit);
    end
  end

  assign bus.zero_o = zero_q;
`endif

  assign bus.ready_o = ready;
  assign bus.valid_o = valid;
  assign bus.diff_o  = diff_q;
endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial: directed corner cases plus random ops.
module tb_subtractor_serial;
  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  subtractor_serial_if #(.width_p(W)) bus ();

  subtractor_serial #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a - b reduced modulo 2^(W+1) is the (W+1)-bit two's-complement result.
  function automatic logic [W:0] model_diff(input int unsigned a, input int unsigned b);
    return (W+1)'(int'(a) - int'(b));
  endfunction

  task automatic do_op(input int unsigned a, input int unsigned b,
                       input int unsigned bp, input bit pulse);
    int n;
    logic [W:0] exp;
    logic [W:0] held;
    exp = model_diff(a, b);
    bus.ready_i = (bp == 0);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(n < 100), 1);
    bus.a_i     = W'(a);
    bus.b_i     = W'(b);
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.a_i     = W'($urandom);
    bus.b_i     = W'($urandom);
    n = 0;
    while (bus.valid_o !== 1'b1 && n < 100) begin
      if (n == 0) chk("busy_ready_o", bus.ready_o, 0);
      if (pulse && n == 1) begin
        bus.valid_i = 1'b1;
        bus.a_i     = W'(1);
        bus.b_i     = W'(2);
      end
      if (pulse && n == 2) bus.valid_i = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("latency", n, W);
    chk("diff", bus.diff_o, exp);
    chk("borrow", bus.diff_o[W], 64'(a < b));
`ifdef SUBTRACTOR_SERIAL_ZERO_FLAG_EN
    chk("zero", bus.zero_o, 64'(a == b));
`endif
    chk("done_ready_o", bus.ready_o, 0);
    held = bus.diff_o;
    repeat (bp) begin
      @(negedge clk);
      chk("bp_valid", bus.valid_o, 1);
      chk("bp_diff", bus.diff_o, held);
      chk("bp_ready", bus.ready_o, 0);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk("ret_valid", bus.valid_o, 0);
    chk("ret_ready", bus.ready_o, 1);
    if (pulse) begin
      repeat (W + 3) begin
        @(negedge clk);
        chk("no_second_valid", bus.valid_o, 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready_o", bus.ready_o, 0);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_diff_o", bus.diff_o, 0);
`ifdef SUBTRACTOR_SERIAL_ZERO_FLAG_EN
    chk("rst_zero_o", bus.zero_o, 0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_ready_o", bus.ready_o, 1);
    @(negedge clk);

    do_op(9, 4, 0, 1'b0);
    chk("const_9_4", bus.diff_o, 6'b000101);
    do_op(4, 9, 0, 1'b0);
    chk("const_4_9", bus.diff_o, 6'b111011);
    do_op(31, 0, 0, 1'b0);
    chk("const_31_0", bus.diff_o, 6'b011111);
    do_op(0, 31, 0, 1'b0);
    chk("const_0_31", bus.diff_o, 6'b100001);
    do_op(17, 17, 0, 1'b0);
    chk("const_17_17", bus.diff_o, 6'b000000);
    do_op(12, 20, 3, 1'b0);
    do_op(9, 4, 0, 1'b1);

    // Reset during the third BUSY cycle.
    bus.ready_i = 1'b1;
    bus.a_i     = W'(9);
    bus.b_i     = W'(4);
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid_o", bus.valid_o, 0);
    chk("midrst_diff_o", bus.diff_o, 0);
    chk("midrst_ready_o", bus.ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", bus.ready_o, 1);
    repeat (W + 2) begin
      @(negedge clk);
      chk("midrst_no_valid", bus.valid_o, 0);
    end
    do_op(3, 1, 0, 1'b0);
    chk("const_3_1", bus.diff_o, 6'b000010);

    for (int i = 0; i < 20; i++) begin
      do_op($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
